fe_branch_redirect_fetch: RTL and testbench
===========================================

// Module: fe_branch_redirect_fetch
// PURPOSE
//   Fetch-stage PC generator and FE pipeline latch; receiving end of the AGEX->FE branch-redirect interface.
//   Reads instruction memory at the current PC and pre-decodes each fetched word.
//   On a fetched branch or jump it stops fetching and inserts bubbles until AGEX reports the outcome.
//   Feeds the decode stage (FE latch) and honours the decode stall.
// PARAMETERS
//   DBITS      32          data/PC width
//   INSTBITS   32          instruction width
//   RESET_PC   32'h0000_0000  PC loaded on reset
// PORTS
//   clk              in   1         clock, all state updates on posedge
//   reset            in   1         synchronous, active-high
//   br_redirect      in   1         AGEX: branch/jump taken, load br_target
//   br_target        in   DBITS     AGEX: redirect target address
//   br_not_taken     in   1         AGEX: branch resolved not-taken, resume sequential fetch
//   de_stall         in   1         DE: hold FE latch and PC
//   imem_addr        out  DBITS     instruction memory address (= pc_q, combinational read)
//   imem_rdata       in   INSTBITS  instruction word at imem_addr, same cycle
//   fe_valid         out  1         FE latch holds a real instruction (0 = bubble)
//   fe_inst          out  INSTBITS  latched instruction
//   fe_pc            out  DBITS     latched PC
//   fe_pcplus        out  DBITS     latched PC+4
//   fe_inst_count    out  DBITS     sequence number of latched instruction
//   misalign_err     out  1         sticky: a redirect target had bits[1:0] != 0
//   bubble_count     out  DBITS     cycles the latch was loaded with a bubble
// BEHAVIOUR
//   Reset:
//     - pc_q=RESET_PC, state=RUN, all latch fields 0, fe_valid=0.
//     - inst_count=0, misalign_err=0, bubble_count=0. Reset overrides everything, including mid-WAIT_BR.
//   Pre-decode: is_cf = imem_rdata[6:0] in {7'b1100011 BR, 7'b1101111 JAL, 7'b1100111 JALR}.
//   Priority per cycle: reset > br_redirect > br_not_taken > de_stall > normal.
//   States: RUN, WAIT_BR.
//   RUN, de_stall=0:
//     - latch <= {1, imem_rdata, pc_q, pc_q+4, inst_count}; pc_q <= pc_q+4; inst_count++.
//     - If is_cf, next state = WAIT_BR.
//   RUN, de_stall=1: pc_q, inst_count, latch, state all hold.
//   WAIT_BR, no AGEX event:
//     - pc_q holds (already branch PC+4); no fetch.
//     - If de_stall=0, latch <= bubble (fe_valid=0, other fields 0) and bubble_count++.
//     - If de_stall=1, latch holds.
//   br_redirect=1 (any state):
//     - pc_q <= {br_target[DBITS-1:2],2'b00}; state <= RUN.
//     - Latch flushed to bubble regardless of de_stall; bubble_count++.
//     - If br_target[1:0]!=0, misalign_err <= 1.
//   br_not_taken=1 in WAIT_BR:
//     - state <= RUN; pc_q unchanged; this cycle latch <= bubble if de_stall=0.
//     - First sequential fetch happens the next cycle.
//   br_not_taken=1 in RUN: ignored.
//   br_redirect and br_not_taken together: treated as br_redirect.
//   Latency: imem_rdata at PC X appears on fe_* the cycle after the fetch edge.
//     - Taken redirect: first target instruction appears 2 edges after br_redirect is sampled.
//   Arithmetic: pc_q+4, inst_count and bubble_count wrap modulo 2^DBITS; no saturation.
//   AGEX signals are sampled only on posedge; no combinational path from AGEX inputs to imem_addr.
// TESTING
//   1. Reset, imem = 4 ADDI words, de_stall=0.
//      -> fe_pc 0,4,8,C on consecutive cycles; fe_inst_count 0..3; fe_valid=1.
//   2. BEQ at 0x8, then br_redirect=1, target=0x40 two cycles later.
//      -> bubbles after 0x8; bubble_count=2; next valid fe_pc=0x40.
//   3. BNE at 0x8, then br_not_taken=1.
//      -> state returns to RUN; next valid fe_pc=0xC; fe_inst_count continues without gap.
//   4. de_stall=1 for 3 cycles during RUN.
//      -> fe_* and imem_addr constant; inst_count unchanged; resumes at the same PC.
//   5. br_redirect with target=0x42 while de_stall=1.
//      -> latch flushed to fe_valid=0; pc_q=0x40; misalign_err=1 and stays 1.
//   6. reset asserted in WAIT_BR.
//      -> next cycle pc=RESET_PC, state RUN, fe_valid=0, all counters 0.

Source files
------------

// File: rtl/fe_branch_redirect_fetch.sv
// fe_branch_redirect_fetch
//   Fetch-stage PC generator and FE pipeline latch. This block receives branch
//   redirects from AGEX. It reads instruction memory combinationally at pc_q and
//   pre-decodes each fetched word. When a fetched word is a branch or jump, it
//   stops fetching and loads bubbles into the latch until AGEX resolves the
//   branch. The decode stall holds both the latch and the PC.
// Ports
//   clk, reset            clock; synchronous active-high reset
//   br_redirect/br_target AGEX taken branch/jump and its target
//   br_not_taken          AGEX branch resolved not-taken
//   de_stall              decode stall: hold latch and PC
//   imem_addr/imem_rdata  instruction memory read port (same-cycle data)
//   fe_valid/fe_inst/fe_pc/fe_pcplus/fe_inst_count   FE latch towards decode
//   misalign_err          sticky flag for a redirect target with bits[1:0] != 0
//   bubble_count          number of cycles the latch was loaded with a bubble
module fe_branch_redirect_fetch #(
  parameter int              DBITS    = 32,
  parameter int              INSTBITS = 32,
  parameter logic [DBITS-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                br_redirect,
  input  logic [DBITS-1:0]    br_target,
  input  logic                br_not_taken,
  input  logic                de_stall,
  output logic [DBITS-1:0]    imem_addr,
  input  logic [INSTBITS-1:0] imem_rdata,
  output logic                fe_valid,
  output logic [INSTBITS-1:0] fe_inst,
  output logic [DBITS-1:0]    fe_pc,
  output logic [DBITS-1:0]    fe_pcplus,
  output logic [DBITS-1:0]    fe_inst_count,
  output logic                misalign_err,
  output logic [DBITS-1:0]    bubble_count
);

  typedef enum logic [0:0] {RUN = 1'b0, WAIT_BR = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [DBITS-1:0]     pc_q;
  logic [DBITS-1:0]     inst_count_q;
  logic [DBITS-1:0]     bubble_count_q;
  logic                 misalign_q;

  logic                 vld_p0;
  logic [INSTBITS-1:0]  inst_p0;
  logic [DBITS-1:0]     pc_p0;
  logic [DBITS-1:0]     pcplus_p0;
  logic [DBITS-1:0]     cnt_p0;

  logic                 is_cf;
  logic                 do_fetch;
  logic                 do_bubble;
  logic                 do_redirect;
  logic [DBITS-1:0]     pc_plus4;

  function automatic logic is_control_flow(input logic [6:0] opcode);
    return (opcode == 7'b1100011) || (opcode == 7'b1101111) ||
           (opcode == 7'b1100111);
  endfunction

  // The PC comes straight from a register, so the AGEX inputs have no
  // combinational path to the memory address.
  assign imem_addr = pc_q;
  assign is_cf     = is_control_flow(imem_rdata[6:0]);
  assign pc_plus4  = pc_q + DBITS'(4);

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Priority: br_redirect > br_not_taken (WAIT_BR only) > de_stall > normal.
  always_comb begin
    state_d     = state_q;
    do_fetch    = 1'b0;
    do_bubble   = 1'b0;
    do_redirect = 1'b0;
    if (br_redirect) begin
      do_redirect = 1'b1;
      state_d     = RUN;
    end else if (br_not_taken && (state_q == WAIT_BR)) begin
      // pc_q already holds branch PC+4. Sequential fetch resumes on the next cycle.
      state_d   = RUN;
      do_bubble = !de_stall;
    end else if (!de_stall) begin
      if (state_q == RUN) begin
        do_fetch = 1'b1;
        if (is_cf) state_d = WAIT_BR;
      end else begin
        do_bubble = 1'b1;
      end
    end
  end

  // FE latch boundary (p0): fetched word or bubble, seen by decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      inst_count_q   <= '0;
      bubble_count_q <= '0;
      misalign_q     <= 1'b0;
      vld_p0         <= 1'b0;
      inst_p0        <= '0;
      pc_p0          <= '0;
      pcplus_p0      <= '0;
      cnt_p0         <= '0;
    end else if (do_redirect) begin
      // A redirect flushes the latch even if decode is stalled, because the
      // instruction held there is on the wrong path.
      pc_q           <= {br_target[DBITS-1:2], 2'b00};
      bubble_count_q <= bubble_count_q + DBITS'(1);
      if (br_target[1:0] != 2'b00) misalign_q <= 1'b1;
      vld_p0         <= 1'b0;
      inst_p0        <= '0;
      pc_p0          <= '0;
      pcplus_p0      <= '0;
      cnt_p0         <= '0;
    end else if (do_bubble) begin
      bubble_count_q <= bubble_count_q + DBITS'(1);
      vld_p0         <= 1'b0;
      inst_p0        <= '0;
      pc_p0          <= '0;
      pcplus_p0      <= '0;
      cnt_p0         <= '0;
    end else if (do_fetch) begin
      pc_q           <= pc_plus4;
      inst_count_q   <= inst_count_q + DBITS'(1);
      vld_p0         <= 1'b1;
      inst_p0        <= imem_rdata;
      pc_p0          <= pc_q;
      pcplus_p0      <= pc_plus4;
      cnt_p0         <= inst_count_q;
    end
  end

  assign fe_valid      = vld_p0;
  assign fe_inst       = inst_p0;
  assign fe_pc         = pc_p0;
  assign fe_pcplus     = pcplus_p0;
  assign fe_inst_count = cnt_p0;
  assign misalign_err  = misalign_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_fe_branch_redirect_fetch.sv
module tb_fe_branch_redirect_fetch;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        br_redirect = 1'b0;
  logic [31:0] br_target = '0;
  logic        br_not_taken = 1'b0;
  logic        de_stall = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        fe_valid;
  logic [31:0] fe_inst;
  logic [31:0] fe_pc;
  logic [31:0] fe_pcplus;
  logic [31:0] fe_inst_count;
  logic        misalign_err;
  logic [31:0] bubble_count;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  assign imem_rdata = mem[imem_addr[7:2]];

  always #5 clk = ~clk;

  fe_branch_redirect_fetch dut (
    .clk(clk), .reset(reset), .br_redirect(br_redirect), .br_target(br_target),
    .br_not_taken(br_not_taken), .de_stall(de_stall), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .fe_valid(fe_valid), .fe_inst(fe_inst), .fe_pc(fe_pc),
    .fe_pcplus(fe_pcplus), .fe_inst_count(fe_inst_count), .misalign_err(misalign_err),
    .bubble_count(bubble_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = ADDI + (i << 7);
  endtask

  task automatic do_reset();
    reset = 1'b1; br_redirect = 1'b0; br_not_taken = 1'b0; de_stall = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fill_mem();
    do_reset();
    checks++; if (fe_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", fe_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", imem_addr); end
    checks++; if ({fe_inst, fe_pc, fe_pcplus, fe_inst_count} !== 128'h0) begin errors++; $display("FAIL reset_latch got %h want 0", {fe_inst, fe_pc, fe_pcplus, fe_inst_count}); end
    checks++; if ({misalign_err, bubble_count} !== 33'h0) begin errors++; $display("FAIL reset_ctrs got %h want 0", {misalign_err, bubble_count}); end
  endtask

  task automatic test_sequential();
    fill_mem();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fe_valid !== 1'b1 || fe_pc !== 32'(4*i) || fe_pcplus !== 32'(4*i+4) ||
          fe_inst_count !== 32'(i) || fe_inst !== (ADDI + 32'(i << 7))) begin
        errors++;
        $display("FAIL seq%0d got v=%0b pc=%h pp=%h cnt=%0d inst=%h want v=1 pc=%h pp=%h cnt=%0d inst=%h",
                 i, fe_valid, fe_pc, fe_pcplus, fe_inst_count, fe_inst,
                 32'(4*i), 32'(4*i+4), i, ADDI + 32'(i << 7));
      end
    end
  endtask

  task automatic test_redirect();
    fill_mem(); mem[2] = BEQ;
    do_reset();
    step(); step(); step();
    checks++; if (fe_pc !== 32'h8 || fe_inst !== BEQ || imem_addr !== 32'hC) begin errors++; $display("FAIL br_fetch got pc=%h inst=%h addr=%h want 8 %h C", fe_pc, fe_inst, imem_addr, BEQ); end
    step();
    checks++; if (fe_valid !== 1'b0 || bubble_count !== 32'd1 || imem_addr !== 32'hC) begin errors++; $display("FAIL br_wait got v=%0b bc=%0d addr=%h want 0 1 C", fe_valid, bubble_count, imem_addr); end
    br_redirect = 1'b1; br_target = 32'h40;
    step();
    br_redirect = 1'b0;
    checks++; if (fe_valid !== 1'b0 || bubble_count !== 32'd2 || imem_addr !== 32'h40) begin errors++; $display("FAIL br_redir got v=%0b bc=%0d addr=%h want 0 2 40", fe_valid, bubble_count, imem_addr); end
    step();
    checks++; if (fe_valid !== 1'b1 || fe_pc !== 32'h40 || fe_inst_count !== 32'd3 || fe_inst !== mem[16] || misalign_err !== 1'b0) begin errors++; $display("FAIL br_target got v=%0b pc=%h cnt=%0d mis=%0b want 1 40 3 0", fe_valid, fe_pc, fe_inst_count, misalign_err); end
  endtask

  task automatic test_not_taken();
    fill_mem(); mem[2] = BNE;
    do_reset();
    step(); step(); step(); step();
    checks++; if (fe_valid !== 1'b0 || bubble_count !== 32'd1) begin errors++; $display("FAIL nt_wait got v=%0b bc=%0d want 0 1", fe_valid, bubble_count); end
    br_not_taken = 1'b1;
    step();
    br_not_taken = 1'b0;
    checks++; if (fe_valid !== 1'b0 || bubble_count !== 32'd2 || imem_addr !== 32'hC) begin errors++; $display("FAIL nt_resolve got v=%0b bc=%0d addr=%h want 0 2 C", fe_valid, bubble_count, imem_addr); end
    step();
    checks++; if (fe_valid !== 1'b1 || fe_pc !== 32'hC || fe_inst_count !== 32'd3) begin errors++; $display("FAIL nt_resume got v=%0b pc=%h cnt=%0d want 1 C 3", fe_valid, fe_pc, fe_inst_count); end
    br_not_taken = 1'b1;
    step();
    br_not_taken = 1'b0;
    checks++; if (fe_valid !== 1'b1 || fe_pc !== 32'h10 || fe_inst_count !== 32'd4 || bubble_count !== 32'd2) begin errors++; $display("FAIL nt_in_run got v=%0b pc=%h cnt=%0d bc=%0d want 1 10 4 2", fe_valid, fe_pc, fe_inst_count, bubble_count); end
  endtask

  task automatic test_stall();
    fill_mem();
    do_reset();
    step(); step();
    de_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fe_valid !== 1'b1 || fe_pc !== 32'h4 || fe_inst_count !== 32'd1 || imem_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall%0d got v=%0b pc=%h cnt=%0d addr=%h want 1 4 1 8", i, fe_valid, fe_pc, fe_inst_count, imem_addr);
      end
    end
    de_stall = 1'b0;
    step();
    checks++; if (fe_valid !== 1'b1 || fe_pc !== 32'h8 || fe_inst_count !== 32'd2) begin errors++; $display("FAIL stall_resume got v=%0b pc=%h cnt=%0d want 1 8 2", fe_valid, fe_pc, fe_inst_count); end
  endtask

  task automatic test_redirect_stall_misalign();
    fill_mem();
    do_reset();
    step(); step();
    de_stall = 1'b1; br_redirect = 1'b1; br_target = 32'h42;
    step();
    br_redirect = 1'b0;
    checks++; if (fe_valid !== 1'b0 || fe_pc !== 32'h0 || fe_inst !== 32'h0 || imem_addr !== 32'h40 || misalign_err !== 1'b1 || bubble_count !== 32'd1) begin errors++; $display("FAIL mis_flush got v=%0b pc=%h inst=%h addr=%h mis=%0b bc=%0d want 0 0 0 40 1 1", fe_valid, fe_pc, fe_inst, imem_addr, misalign_err, bubble_count); end
    step();
    checks++; if (fe_valid !== 1'b0 || imem_addr !== 32'h40 || bubble_count !== 32'd1) begin errors++; $display("FAIL mis_hold got v=%0b addr=%h bc=%0d want 0 40 1", fe_valid, imem_addr, bubble_count); end
    de_stall = 1'b0;
    step();
    checks++; if (fe_valid !== 1'b1 || fe_pc !== 32'h40 || fe_inst_count !== 32'd2 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_target got v=%0b pc=%h cnt=%0d mis=%0b want 1 40 2 1", fe_valid, fe_pc, fe_inst_count, misalign_err); end
  endtask

  task automatic test_reset_in_wait();
    fill_mem(); mem[2] = BEQ;
    do_reset();
    br_redirect = 1'b1; br_target = 32'h1;
    step();
    br_redirect = 1'b0;
    step(); step(); step(); step();
    checks++; if (fe_valid !== 1'b0 || bubble_count !== 32'd2 || misalign_err !== 1'b1) begin errors++; $display("FAIL rw_pre got v=%0b bc=%0d mis=%0b want 0 2 1", fe_valid, bubble_count, misalign_err); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (imem_addr !== 32'h0 || fe_valid !== 1'b0 || bubble_count !== 32'd0 || misalign_err !== 1'b0 || fe_inst_count !== 32'd0) begin errors++; $display("FAIL rw_reset got addr=%h v=%0b bc=%0d mis=%0b cnt=%0d want 0 0 0 0 0", imem_addr, fe_valid, bubble_count, misalign_err, fe_inst_count); end
    step();
    checks++; if (fe_valid !== 1'b1 || fe_pc !== 32'h0 || fe_inst_count !== 32'd0) begin errors++; $display("FAIL rw_run got v=%0b pc=%h cnt=%0d want 1 0 0", fe_valid, fe_pc, fe_inst_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_not_taken();
    test_stall();
    test_redirect_stall_misalign();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
